// File: rtl/sine_dac_sequencer_pkg.sv
// Shared definitions for the sine DAC sequencer: state encoding, DAC channel
// codes and divider defaults.
package sine_dac_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_B,
        ST_CAP_B,
        ST_SEND_A,
        ST_WAIT_A,
        ST_SEND_B,
        ST_WAIT_B
    } seq_state_t;

    localparam logic DAC_CHAN_A = 1'b0;
    localparam logic DAC_CHAN_B = 1'b1;

    localparam int unsigned DEFAULT_DIV_COUNT = 5000;
    localparam int unsigned DIV_WIDTH         = 16;

endpackage

// File: rtl/sine_dac_sequencer_if.sv
// Shared ROM read port and spi2dac request bus driven by the sequencer.
interface sine_dac_sequencer_if #(
    parameter int unsigned A_BITS = 10,
    parameter int unsigned D_BITS = 10
);

    logic [A_BITS-1:0] ROM_ADDR;
    logic              ROM_EN;
    logic [D_BITS-1:0] ROM_DATA;
    logic [D_BITS-1:0] DAC_DATA;
    logic              DAC_CHAN;
    logic              DAC_START;
    logic              DAC_BUSY;

    modport master (
        output ROM_ADDR,
        output ROM_EN,
        input  ROM_DATA,
        output DAC_DATA,
        output DAC_CHAN,
        output DAC_START,
        input  DAC_BUSY
    );

    modport slave (
        input  ROM_ADDR,
        input  ROM_EN,
        output ROM_DATA,
        input  DAC_DATA,
        input  DAC_CHAN,
        input  DAC_START,
        output DAC_BUSY
    );

endinterface

// File: rtl/sine_dac_sequencer_sample_tick_div.sv
// Free-running divider: counts 0..DIV_COUNT-1 and flags the last count as the
// sample tick.
module sample_tick_div
    import sine_dac_sequencer_pkg::*;
#(
    parameter int unsigned DIV_COUNT = DEFAULT_DIV_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + DIV_WIDTH'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sine_dac_sequencer.sv
// Two-channel phase-accumulator sequencer: per sample tick it reads the shared
// sine ROM for both channels and hands both samples to the single SPI DAC.
module sine_dac_sequencer
    import sine_dac_sequencer_pkg::*;
#(
    parameter int unsigned DIV_COUNT = DEFAULT_DIV_COUNT,
    parameter int unsigned A_BITS    = 10,
    parameter int unsigned D_BITS    = 10
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET_N,
    input  logic                        ENABLE,
    input  logic [A_BITS-1:0]           STEP_A,
    input  logic [A_BITS-1:0]           STEP_B,
    sine_dac_sequencer_if.master        bus,
    output logic [D_BITS-1:0]           PWM_DATA,
    output logic                        SAMPLE_TICK,
    output logic                        OVERRUN
);

    seq_state_t        state;
    logic [A_BITS-1:0] phase_a;
    logic [A_BITS-1:0] phase_b;
    logic [A_BITS-1:0] step_a;
    logic [A_BITS-1:0] step_b;
    logic [D_BITS-1:0] sample_a;
    logic [D_BITS-1:0] sample_b;
    logic [A_BITS-1:0] rom_addr;
    logic              rom_en;
    logic [D_BITS-1:0] dac_data;
    logic              dac_chan;
    logic [D_BITS-1:0] pwm_data;
    logic              overrun;
    logic              settle;

    sample_tick_div #(
        .DIV_COUNT (DIV_COUNT)
    ) u_div (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .tick  (SAMPLE_TICK)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            phase_a  <= '0;
            phase_b  <= '0;
            step_a   <= '0;
            step_b   <= '0;
            sample_a <= '0;
            sample_b <= '0;
            rom_addr <= '0;
            rom_en   <= 1'b0;
            dac_data <= '0;
            dac_chan <= DAC_CHAN_A;
            pwm_data <= '0;
            overrun  <= 1'b0;
            settle   <= 1'b0;
        end else begin
            if (SAMPLE_TICK && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (SAMPLE_TICK && ENABLE) begin
                        step_a   <= STEP_A;
                        step_b   <= STEP_B;
                        rom_addr <= phase_a;
                        rom_en   <= 1'b1;
                        state    <= ST_FETCH_A;
                    end
                end
                ST_FETCH_A: begin
                    rom_addr <= phase_b;
                    rom_en   <= 1'b1;
                    state    <= ST_FETCH_B;
                end
                ST_FETCH_B: begin
                    sample_a <= bus.ROM_DATA;
                    rom_en   <= 1'b0;
                    state    <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    sample_b <= bus.ROM_DATA;
                    dac_data <= sample_a;
                    dac_chan <= DAC_CHAN_A;
                    state    <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    if (!bus.DAC_BUSY) begin
                        pwm_data <= sample_a;
                        settle   <= 1'b1;
                        state    <= ST_WAIT_A;
                    end
                end
                // BUSY only rises the cycle after START, so the first WAIT cycle is skipped.
                ST_WAIT_A: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (!bus.DAC_BUSY) begin
                        dac_data <= sample_b;
                        dac_chan <= DAC_CHAN_B;
                        state    <= ST_SEND_B;
                    end
                end
                ST_SEND_B: begin
                    if (!bus.DAC_BUSY) begin
                        settle <= 1'b1;
                        state  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (settle) begin
                        settle <= 1'b0;
                    end else if (!bus.DAC_BUSY) begin
                        phase_a <= phase_a + step_a;
                        phase_b <= phase_b + step_b;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // START is gated by live BUSY so it fires within the SEND cycle itself and
    // can never coincide with a busy serialiser.
    assign bus.DAC_START = ((state == ST_SEND_A) || (state == ST_SEND_B)) && !bus.DAC_BUSY;

    assign bus.ROM_ADDR = rom_addr;
    assign bus.ROM_EN   = rom_en;
    assign bus.DAC_DATA = dac_data;
    assign bus.DAC_CHAN = dac_chan;
    assign PWM_DATA     = pwm_data;
    assign OVERRUN      = overrun;

endmodule

// File: tb/tb_sine_dac_sequencer.sv
// Directed bench for sine_dac_sequencer with a data=address ROM model and a
// k-cycle spi2dac busy model.
module tb_sine_dac_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 10;

    logic          clk = 1'b0;
    logic          RESET_N = 1'b0;
    logic          ENABLE = 1'b0;
    logic [AW-1:0] STEP_A = '0;
    logic [AW-1:0] STEP_B = '0;
    logic [DW-1:0] PWM_DATA;
    logic          SAMPLE_TICK;
    logic          OVERRUN;

    logic busy_force = 1'b0;
    int   busy_len = 3;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   last_tick = 0;
    int   tick_gap = 0;
    int   tick_count = 0;
    int   viol = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic          chan;
        logic [DW-1:0] data;
        logic [DW-1:0] pwm;
        int            lat;
    } xfer_t;

    typedef struct {
        logic chan;
        int   data;
        int   pwm;
        int   lat;
    } vec_t;

    xfer_t         dac_q[$];
    logic [AW-1:0] rom_q[$];
    vec_t          tbl[6];

    sine_dac_sequencer_if #(.A_BITS(AW), .D_BITS(DW)) dut_if ();

    sine_dac_sequencer #(
        .DIV_COUNT (16),
        .A_BITS    (AW),
        .D_BITS    (DW)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (RESET_N),
        .ENABLE      (ENABLE),
        .STEP_A      (STEP_A),
        .STEP_B      (STEP_B),
        .bus         (dut_if),
        .PWM_DATA    (PWM_DATA),
        .SAMPLE_TICK (SAMPLE_TICK),
        .OVERRUN     (OVERRUN)
    );

    always #5 clk = ~clk;

    initial dut_if.ROM_DATA = '0;

    // ROM returns its address one cycle after the strobe; BUSY rises after START.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dut_if.ROM_EN) dut_if.ROM_DATA <= dut_if.ROM_ADDR;
        if (dut_if.DAC_START) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign dut_if.DAC_BUSY = (busy_cnt != 0) || busy_force;

    always @(negedge clk) begin : mon
        xfer_t x;
        if (dut_if.DAC_START) begin
            x.chan = dut_if.DAC_CHAN;
            x.data = dut_if.DAC_DATA;
            x.pwm  = PWM_DATA;
            x.lat  = cyc - last_tick;
            dac_q.push_back(x);
            if (dut_if.DAC_BUSY) viol++;
        end
        if (dut_if.ROM_EN) rom_q.push_back(dut_if.ROM_ADDR);
        if (SAMPLE_TICK) begin
            tick_gap  = cyc - last_tick;
            last_tick = cyc;
            tick_count++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_dac(input int n, input int budget);
        int i = 0;
        while (dac_q.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("wait_dac_entries", int'(dac_q.size() >= n), 1);
    endtask

    task automatic wait_rom(input int n, input int budget);
        int i = 0;
        while (rom_q.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("wait_rom_entries", int'(rom_q.size() >= n), 1);
    endtask

    task automatic check_xfer(input string tag, input int i, input logic chan, input int data);
        if (i < dac_q.size()) begin
            check({tag, "_chan"}, int'(dac_q[i].chan), int'(chan));
            check({tag, "_data"}, int'(dac_q[i].data), data);
        end else begin
            check({tag, "_present"}, 0, 1);
        end
    endtask

    task automatic do_reset();
        RESET_N    = 1'b0;
        ENABLE     = 1'b0;
        busy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dac_q.delete();
        rom_q.delete();
        RESET_N = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int t0;
        int d0;

        tbl[0] = '{1'b0, 0, 0, 4};
        tbl[1] = '{1'b1, 0, 0, 9};
        tbl[2] = '{1'b0, 1, 0, 4};
        tbl[3] = '{1'b1, 4, 1, 9};
        tbl[4] = '{1'b0, 2, 1, 4};
        tbl[5] = '{1'b1, 8, 2, 9};

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_rom_addr",  int'(dut_if.ROM_ADDR), 0);
        check("rst_rom_en",    int'(dut_if.ROM_EN), 0);
        check("rst_dac_data",  int'(dut_if.DAC_DATA), 0);
        check("rst_dac_chan",  int'(dut_if.DAC_CHAN), 0);
        check("rst_dac_start", int'(dut_if.DAC_START), 0);
        check("rst_pwm",       int'(PWM_DATA), 0);
        check("rst_tick",      int'(SAMPLE_TICK), 0);
        check("rst_overrun",   int'(OVERRUN), 0);

        // Basic two-channel run, step 1 / 4, busy 3 cycles
        do_reset();
        STEP_A   = 10'd1;
        STEP_B   = 10'd4;
        busy_len = 3;
        ENABLE   = 1'b1;
        wait_dac(6, 200);
        for (int i = 0; i < 6; i++) begin
            if (i < dac_q.size()) begin
                check($sformatf("run_chan%0d", i), int'(dac_q[i].chan), int'(tbl[i].chan));
                check($sformatf("run_data%0d", i), int'(dac_q[i].data), tbl[i].data);
                check($sformatf("run_pwm%0d", i),  int'(dac_q[i].pwm),  tbl[i].pwm);
                check($sformatf("run_lat%0d", i),  dac_q[i].lat,        tbl[i].lat);
            end else begin
                check($sformatf("run_present%0d", i), 0, 1);
            end
        end
        check("run_rom_a2", (rom_q.size() > 4) ? int'(rom_q[4]) : -1, 2);
        check("run_rom_b2", (rom_q.size() > 5) ? int'(rom_q[5]) : -1, 8);

        // Phase wrap: step 1000 over three ticks
        do_reset();
        STEP_A = 10'd1000;
        STEP_B = 10'd0;
        ENABLE = 1'b1;
        wait_rom(6, 200);
        check("wrap_a0", (rom_q.size() > 0) ? int'(rom_q[0]) : -1, 0);
        check("wrap_a1", (rom_q.size() > 2) ? int'(rom_q[2]) : -1, 1000);
        check("wrap_a2", (rom_q.size() > 4) ? int'(rom_q[4]) : -1, 976);
        check("wrap_b2", (rom_q.size() > 5) ? int'(rom_q[5]) : -1, 0);

        // Overrun: BUSY stuck high for 40 cycles
        do_reset();
        STEP_A     = 10'd1;
        STEP_B     = 10'd4;
        busy_force = 1'b1;
        ENABLE     = 1'b1;
        wait_rom(1, 100);
        check("ovr_before", int'(OVERRUN), 0);
        repeat (40) @(posedge clk);
        #1;
        check("ovr_set",      int'(OVERRUN), 1);
        check("ovr_no_start", dac_q.size(), 0);
        check("ovr_no_fetch", rom_q.size(), 2);
        busy_force = 1'b0;
        wait_dac(4, 200);
        check_xfer("ovr_x0", 0, 1'b0, 0);
        check_xfer("ovr_x1", 1, 1'b1, 0);
        check_xfer("ovr_x2", 2, 1'b0, 1);
        check_xfer("ovr_x3", 3, 1'b1, 4);
        check("ovr_sticky", int'(OVERRUN), 1);

        // ENABLE low for two ticks after one completed sequence
        do_reset();
        ENABLE = 1'b1;
        wait_dac(2, 100);
        ENABLE = 1'b0;
        t0 = tick_count;
        r0 = rom_q.size();
        d0 = dac_q.size();
        repeat (32) @(posedge clk);
        #1;
        check("dis_ticks",    tick_count - t0, 2);
        check("dis_tick_gap", tick_gap, 16);
        check("dis_no_fetch", rom_q.size() - r0, 0);
        check("dis_no_start", dac_q.size() - d0, 0);
        ENABLE = 1'b1;
        wait_rom(r0 + 2, 100);
        check("dis_phase_a", (rom_q.size() > r0) ? int'(rom_q[r0]) : -1, 1);
        check("dis_phase_b", (rom_q.size() > r0 + 1) ? int'(rom_q[r0 + 1]) : -1, 4);

        // Asynchronous reset while in WAIT_A of the second sequence
        do_reset();
        ENABLE = 1'b1;
        wait_dac(3, 200);
        check("arst_pre_data", int'(dut_if.DAC_DATA), 1);
        check("arst_pre_pwm",  int'(PWM_DATA), 1);
        RESET_N = 1'b0;
        #1;
        check("arst_rom_addr",  int'(dut_if.ROM_ADDR), 0);
        check("arst_rom_en",    int'(dut_if.ROM_EN), 0);
        check("arst_dac_data",  int'(dut_if.DAC_DATA), 0);
        check("arst_dac_chan",  int'(dut_if.DAC_CHAN), 0);
        check("arst_dac_start", int'(dut_if.DAC_START), 0);
        check("arst_pwm",       int'(PWM_DATA), 0);
        check("arst_overrun",   int'(OVERRUN), 0);
        repeat (3) @(posedge clk);
        #1;
        check("arst_no_start", dac_q.size(), 3);
        dac_q.delete();
        rom_q.delete();
        RESET_N = 1'b1;
        wait_dac(2, 100);
        check_xfer("arst_x0", 0, 1'b0, 0);
        check_xfer("arst_x1", 1, 1'b1, 0);

        // BUSY already high on entry to SEND_A
        do_reset();
        busy_len   = 1;
        busy_force = 1'b1;
        ENABLE     = 1'b1;
        wait_rom(1, 100);
        repeat (6) @(posedge clk);
        #1;
        check("pre_busy_held", dac_q.size(), 0);
        busy_force = 1'b0;
        wait_dac(2, 100);
        check_xfer("pre_busy_x0", 0, 1'b0, 0);
        check_xfer("pre_busy_x1", 1, 1'b1, 0);
        check("pre_busy_late", (dac_q.size() > 0) ? int'(dac_q[0].lat > 4) : 0, 1);
        repeat (6) @(posedge clk);
        #1;
        check("pre_busy_no_ovr", int'(OVERRUN), 0);

        check("start_while_busy", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sine_dac_sequencer.md
# sine_dac_sequencer

Sequencer that drives the sine-generator datapath. It divides CLOCK_50 down to a sample tick and keeps two independent phase accumulators (channel A and channel B). Each tick it time-shares the single synchronous sine ROM port between both channels, then hands both samples, one after the other, to the single SPI DAC serialiser. It sits between the free-running clock domain logic and the shared ROM / spi2dac / pwm instances, and replaces ad-hoc address counters.

## Interface
Parameters:
- DIV_COUNT, 5000: CLOCK_50 cycles per sample tick (10 kHz at 50 MHz); legal range 16..65535.
- A_BITS, 10: ROM address / phase width.
- D_BITS, 10: ROM data / sample width.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  when low, ticks do not start sequences; an in-flight sequence completes.
- STEP_A  in  A_BITS  phase increment for channel A, sampled at tick.
- STEP_B  in  A_BITS  phase increment for channel B, sampled at tick.
- ROM_ADDR  out  A_BITS  shared ROM address.
- ROM_EN  out  1  ROM read strobe; data valid on ROM_DATA the following cycle.
- ROM_DATA  in  D_BITS  ROM read data.
- DAC_DATA  out  D_BITS  sample to spi2dac, stable while DAC_START is high and until BUSY drops.
- DAC_CHAN  out  1  0 = DAC channel A, 1 = channel B.
- DAC_START  out  1  one-cycle request to spi2dac.
- DAC_BUSY  in  1  spi2dac busy; must rise the cycle after DAC_START.
- PWM_DATA  out  D_BITS  last channel-A sample, held for pwm.
- SAMPLE_TICK  out  1  one-cycle tick pulse (for pwm/diagnostics).
- OVERRUN  out  1  sticky; set when a tick arrives while not IDLE.

## Operation
- Divider: counts 0..DIV_COUNT-1 and wraps. SAMPLE_TICK is high for the one cycle in which the count equals DIV_COUNT-1. The divider free-runs regardless of ENABLE.
- States: IDLE, FETCH_A, FETCH_B, CAP_B, SEND_A, WAIT_A, SEND_B, WAIT_B.
- IDLE: on SAMPLE_TICK with ENABLE=1, latch STEP_A/STEP_B and go to FETCH_A.
- FETCH_A: ROM_EN=1, ROM_ADDR=phase_a.
- FETCH_B: ROM_EN=1, ROM_ADDR=phase_b; register ROM_DATA as sample_a.
- CAP_B: register ROM_DATA as sample_b.
- SEND_A: wait while DAC_BUSY=1. When DAC_BUSY=0, pulse DAC_START with DAC_CHAN=0, DAC_DATA=sample_a, and load PWM_DATA with sample_a; then go to WAIT_A.
- WAIT_A: ignore the first cycle. Leave to SEND_B on the first subsequent cycle with DAC_BUSY=0.
- SEND_B and WAIT_B: same as SEND_A and WAIT_A with DAC_CHAN=1 and sample_b. On exit from WAIT_B: phase_a += latched step_a, phase_b += latched step_b, both modulo 2^A_BITS (natural wrap, no saturation); go to IDLE.
- ROM_EN=0 and DAC_START=0 in all other states. ROM_ADDR holds its last value.
- Overrun: a SAMPLE_TICK in any non-IDLE state sets OVERRUN; that tick is dropped and phases do not advance. OVERRUN clears only on reset.
- STEP=0 gives a constant output; STEP=512 toggles between address 0 and 512.

## Timing
- Reset (async assert; deassert sampled on the next edge): state=IDLE, divider=0, phases=0, sample/PWM_DATA/DAC_DATA/ROM_ADDR=0, DAC_CHAN=0, ROM_EN/DAC_START/SAMPLE_TICK/OVERRUN=0.
- Reset mid-sequence aborts immediately with no further DAC_START. spi2dac is reset separately.
- Tick at cycle T gives FETCH_A at T+1, FETCH_B at T+2, CAP_B at T+3, and the first DAC_START at T+4 if DAC_BUSY=0.
- Minimum sequence with a k-cycle busy per transfer: 4 + 2·(k+2) cycles. This must be less than DIV_COUNT, otherwise OVERRUN is set.
- DAC_START is never asserted while DAC_BUSY=1.

## Structure
- A shared package holds the state enumeration, the DAC_CHAN_A/DAC_CHAN_B constants and the default DIV_COUNT.
- One sub-module, sample_tick_div (parameterised divider producing SAMPLE_TICK); the FSM and accumulators stay in the top.

## Test plan
- Reset, DIV_COUNT=16, ENABLE=1, STEP_A=1, STEP_B=4, ROM returns data=address, BUSY model 3 cycles -> DAC sends ch0:0, ch1:0, then ch0:1, ch1:4, then ch0:2, ch1:8. PWM_DATA tracks channel A.
- STEP_A=1000 over 3 ticks -> ROM_ADDR sequence 0, 1000, 976 (wraps at 1024).
- BUSY held high 40 cycles with DIV_COUNT=16 -> OVERRUN=1 after the next tick; phases advance only once per completed sequence.
- ENABLE low for 2 ticks -> no ROM_EN and no DAC_START, phases frozen, SAMPLE_TICK still pulses every 16 cycles.
- Assert RESET_N=0 during WAIT_A -> all outputs return to reset values asynchronously. After release, the next sequence starts from phase 0.
- DAC_BUSY already high entering SEND_A -> DAC_START withheld until BUSY=0, then a single pulse.
